// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Single-port memory arbiter (loader > data > fetch) with tagged
//            1-cycle read return; optional fetch starvation guard enabled by
//            the ARB_STARVE_GUARD_EN macro.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    starve_cnt
);

  localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);

  logic          w_promote;
  logic          w_rd_issue;
  logic [2:0]    w_starve_cnt;
  logic          r_rd_pend;
  logic          r_rd_dm;
  logic [DW-1:0] r_if_hold;
  logic [DW-1:0] r_dm_hold;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit c_guard_en = 1'b1;
  logic [2:0] r_starve_cnt;

  // Loader cycles freeze the count: fetch was not denied by data there.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 3'd0;
    end else if (if_req && !if_gnt && !ld_req) begin
      if (r_starve_cnt != c_starve_max)
        r_starve_cnt <= r_starve_cnt + 3'd1;
    end else if (if_gnt || !if_req) begin
      r_starve_cnt <= 3'd0;
    end
  end
  assign w_starve_cnt = r_starve_cnt;
`else
  localparam bit c_guard_en = 1'b0;
  assign w_starve_cnt = 3'd0;
`endif

  assign starve_cnt = w_starve_cnt;
  assign w_promote  = c_guard_en && (w_starve_cnt == c_starve_max) && !ld_req;

  always_comb begin
    ld_gnt = ld_req;
    dm_gnt = 1'b0;
    if_gnt = 1'b0;
    if (!ld_req) begin
      if (if_req && (w_promote || !dm_req))
        if_gnt = 1'b1;
      else
        dm_gnt = dm_req;
    end
  end

  always_comb begin
    mem_en    = ld_gnt | dm_gnt | if_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  assign w_rd_issue = if_gnt | (dm_gnt & ~dm_we);

  assign if_rvalid = r_rd_pend & ~r_rd_dm;
  assign dm_rvalid = r_rd_pend &  r_rd_dm;
  assign if_rdata  = if_rvalid ? mem_rdata : r_if_hold;
  assign dm_rdata  = dm_rvalid ? mem_rdata : r_dm_hold;

  // Owner tag for the read in flight; the hold registers keep the last return.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rd_dm   <= 1'b0;
      r_if_hold <= '0;
      r_dm_hold <= '0;
    end else begin
      r_rd_pend <= w_rd_issue;
      r_rd_dm   <= dm_gnt;
      if (if_rvalid) r_if_hold <= mem_rdata;
      if (dm_rvalid) r_dm_hold <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter; directed scenarios plus
//            random traffic against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic if_req = 0, dm_req = 0, dm_we = 0, ld_req = 0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0, ld_addr = '0;
  logic [DW-1:0] dm_wdata = '0, ld_wdata = '0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, mem_en, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [2:0]    starve_cnt;

  always #5 clk1 = ~clk1;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  // Environment memory: registered read, write lands at the issue edge.
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit e_ld, e_dm, e_if;
  bit x_if_rv, x_dm_rv;
  logic [DW-1:0] x_if_rd, x_dm_rd;
  int sc;
  bit seen_if_gnt;
  int max_sc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    x_if_rv = 0; x_dm_rv = 0; x_if_rd = '0; x_dm_rd = '0; sc = 0;
  endtask

  task automatic step();
    logic [AW-1:0] xa;
    logic [DW-1:0] xw;
    logic          xwe;
    @(negedge clk1);
    e_ld = ld_req; e_dm = 0; e_if = 0;
    if (!ld_req) begin
      if (if_req && dm_req) begin
        if (GUARD && sc >= STARVE_MAX) e_if = 1; else e_dm = 1;
      end else if (dm_req) e_dm = 1;
      else if (if_req) e_if = 1;
    end
    xa = '0; xw = '0; xwe = 0;
    if (e_ld)      begin xa = ld_addr; xw = ld_wdata; xwe = 1; end
    else if (e_dm) begin xa = dm_addr; xw = dm_wdata; xwe = dm_we; end
    else if (e_if) begin xa = if_addr; end
    check("ld_gnt", ld_gnt, e_ld);
    check("dm_gnt", dm_gnt, e_dm);
    check("if_gnt", if_gnt, e_if);
    check("mem_en", mem_en, e_ld | e_dm | e_if);
    check("mem_we", mem_we, xwe);
    check("mem_addr", mem_addr, xa);
    check("mem_wdata", mem_wdata, xw);
    check("if_rvalid", if_rvalid, x_if_rv);
    check("if_rdata", if_rdata, x_if_rd);
    check("dm_rvalid", dm_rvalid, x_dm_rv);
    check("dm_rdata", dm_rdata, x_dm_rd);
    check("starve_cnt", starve_cnt, sc);
    seen_if_gnt = if_gnt;
    if (int'(starve_cnt) > max_sc) max_sc = int'(starve_cnt);
    @(posedge clk1);
    x_if_rv = 0; x_dm_rv = 0;
    if (e_if) begin x_if_rv = 1; x_if_rd = ref_mem[if_addr]; end
    if (e_dm && !dm_we) begin x_dm_rv = 1; x_dm_rd = ref_mem[dm_addr]; end
    if (e_ld) ref_mem[ld_addr] = ld_wdata;
    if (e_dm && dm_we) ref_mem[dm_addr] = dm_wdata;
    if (GUARD) begin
      if (if_req && !e_if && !ld_req) sc = (sc < STARVE_MAX) ? sc + 1 : sc;
      else if (e_if || !if_req) sc = 0;
    end
    #1;
  endtask

  task automatic retire();
    if (e_ld) ld_req = 0;
    if (e_dm) dm_req = 0;
    if (e_if) if_req = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_clear();
    @(negedge clk1);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_dm_rvalid", dm_rvalid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_starve_cnt", starve_cnt, 0);
    check("rst_mem_en", mem_en, 0);
    @(posedge clk1);
    #1 rst = 0;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_req = 1; ld_addr = a; ld_wdata = d;
    step();
    ld_req = 0;
  endtask

  int first_if;

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin mem_arr[i] = '0; ref_mem[i] = '0; end
    model_clear();
    max_sc = 0;
    do_reset();

    // Reset while a fetch read is in flight
    if_req = 1; if_addr = 5;
    step();
    if_req = 0;
    do_reset();
    step();
    step();

    // Image load
    load_word(0, 32'h11);
    load_word(1, 32'h22);
    load_word(2, 32'h33);
    load_word(8, 32'hABCD);

    // Fetch stream
    if_req = 1;
    for (int a = 0; a < 3; a++) begin
      if_addr = AW'(a);
      step();
    end
    if_req = 0;
    step();
    step();

    // Data beats fetch on a tie
    if_req = 1; if_addr = 0; dm_req = 1; dm_we = 0; dm_addr = 8;
    step(); retire();
    step(); retire();
    step();

    // Loader preempts both, then readback
    ld_req = 1; ld_addr = 3; ld_wdata = 32'hDEAD;
    if_req = 1; if_addr = 1; dm_req = 1; dm_we = 0; dm_addr = 2;
    for (int i = 0; i < 4; i++) begin step(); retire(); end
    dm_req = 1; dm_we = 0; dm_addr = 3;
    step(); retire();
    step();

    // Store then load same address in consecutive cycles
    dm_req = 1; dm_we = 1; dm_addr = 12; dm_wdata = 32'hC0FFEE;
    step();
    dm_we = 0;
    step(); retire();
    step();

    // Starvation: data held six cycles alongside a fetch stream
    first_if = -1; max_sc = 0;
    if_req = 1; if_addr = 4; dm_req = 1; dm_we = 0; dm_addr = 8;
    for (int i = 0; i < 6; i++) begin
      step();
      if (seen_if_gnt && first_if < 0) first_if = i;
      if (e_if) if_addr = if_addr + 1'b1;
      if (e_dm) dm_addr = AW'(i);
    end
    dm_req = 0;
    for (int i = 6; i < 8; i++) begin
      step();
      if (seen_if_gnt && first_if < 0) first_if = i;
    end
    if_req = 0;
    step();
    check("starve_first_if_gnt", first_if, GUARD ? STARVE_MAX : 6);
    check("starve_peak", max_sc, GUARD ? STARVE_MAX : 0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if (!ld_req && $urandom_range(15) == 0) begin
        ld_req = 1; ld_addr = AW'($urandom_range(15)); ld_wdata = $urandom;
      end
      if (!dm_req && $urandom_range(1) == 1) begin
        dm_req = 1; dm_we = 1'($urandom_range(1)); dm_addr = AW'($urandom_range(15)); dm_wdata = $urandom;
      end
      if (!if_req && $urandom_range(3) != 0) begin
        if_req = 1; if_addr = AW'($urandom_range(15));
      end
      step();
      retire();
    end
    ld_req = 0; dm_req = 0; if_req = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the mips32 pipeline; it shares one word-addressed memory between three requesters. The requesters are instruction fetch (IF stage), data access (MEM stage LW/SW) and a program loader that writes the image before run. It issues at most one memory command per cycle, returns read data one cycle later tagged to the requester that issued it, and optionally guards fetch against starvation by back-to-back data accesses.

## Interface
- AW, 10, word address width (memory depth 2^AW words)
- DW, 32, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is promoted (guard build only)

One clock; reset is asynchronous and active-high.

- clk1  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch read request
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch command issued this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DW  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data word address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data command issued this cycle
- dm_rvalid  out  1  dm_rdata valid (loads only)
- dm_rdata  out  DW  load data
- ld_req  in  1  loader write request
- ld_addr  in  AW  loader word address
- ld_wdata  in  DW  loader write data
- ld_gnt  out  1  loader write issued this cycle
- mem_en  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, registered by memory, valid the cycle after a read command
- starve_cnt  out  3  current fetch starvation count (0 when guard compiled out)

## Operation
- Grant selection is combinational from the current requests and registered state. Exactly one of ld_gnt/dm_gnt/if_gnt is high when any request is high; none is high otherwise.
- Base priority: loader > data > fetch.
- The granted requester drives mem_addr/mem_we/mem_wdata, and mem_en = OR of the grants.
  - Fetch: mem_we = 0.
  - Data: mem_we = dm_we.
  - Loader: mem_we = 1.
- Read-owner register: on a granted read, it records the owner (IF or DM) and sets rd_pend. Next cycle, mem_rdata is routed to the owner's rdata and its rvalid pulses for one cycle. The other rvalid stays 0.
- if_rdata/dm_rdata hold their last returned value when rvalid = 0.
- Stores and loader writes produce no rvalid.
- A requester keeps req, addr and data stable until its gnt is seen; a deasserted req is not remembered.
- Starvation counter (guard build):
  - increments when if_req = 1, if_gnt = 0 and ld_req = 0;
  - saturates at STARVE_MAX;
  - clears on if_gnt, or when if_req = 0.
  - When starve_cnt == STARVE_MAX and ld_req = 0, fetch takes priority over data for that cycle.

## Timing
- Reset values:
  - starve_cnt = 0, rd_pend = 0.
  - if_rvalid = 0, dm_rvalid = 0.
  - if_rdata = 0, dm_rdata = 0.
  - Combinational outputs follow their inputs. With no requests: all gnt = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Grant latency is 0 cycles (same cycle as req, if highest priority). Read data latency is 1 cycle after the grant.
- Back-to-back reads are legal every cycle. A read in cycle N and another in cycle N+1 return in N+1 and N+2, each to its own owner.
- Reset asserted with rd_pend = 1: the pending return is discarded and no rvalid follows reset release.
- Loader is never blocked. While ld_req is held, fetch and data wait indefinitely and the starvation counter does not advance.
- A store followed by a load to the same address in the next cycle returns the new data; memory write-before-read ordering is by issue cycle.
- starve_cnt saturates and never wraps. It is 3 bits, so STARVE_MAX ≤ 7.

## Configuration
- ARB_STARVE_GUARD_EN defined: the starvation counter and fetch promotion are as above.
- ARB_STARVE_GUARD_EN undefined: strict loader > data > fetch priority, no counter, starve_cnt tied to 0.

## Test plan
- Reset mid-read: if_req at addr 5 granted, rst pulsed next cycle → if_rvalid stays 0, starve_cnt = 0, all rdata = 0 after release.
- Fetch stream: if_req held, addrs 0,1,2 with mem holding 0x11,0x22,0x33 → if_gnt each cycle, if_rvalid for 3 cycles one cycle later with 0x11, 0x22, 0x33.
- Simultaneous if_req + dm_req load addr 8 (mem = 0xABCD) → dm_gnt first and dm_rdata = 0xABCD next cycle; if_gnt the following cycle.
- Loader preemption: ld_req writing 0xDEAD to addr 3 while if_req and dm_req are high → ld_gnt, mem_we = 1, no other gnt; starve_cnt unchanged; later read of addr 3 returns 0xDEAD.
- Starvation (guard, STARVE_MAX = 4): dm_req held 6 cycles plus if_req → fetch denied 4 cycles, starve_cnt = 4, if_gnt in cycle 5, count returns to 0.
- Guard compiled out: same stimulus → if_gnt only after dm_req drops; starve_cnt = 0 throughout.
